dual_rail_requester: RTL
========================

Name: dual_rail_requester

Overview:
- Clocked client-side bridge sitting directly upstream of the two-user dual-rail bus arbiter. It drives one user's `*_input` lanes and consumes that user's `*_output` lanes.
- Converts a synchronous valid/ready request word into a two-phase dual-rail transition on `bus_input`.
- Waits for the matching two-phase completion on `bus_output`, decodes it, and returns it on a synchronous valid/ready response channel.
- Lets clocked logic issue work to the asynchronous core.

Parameters:
- INPUT, 32, number of Dual lanes in the request word (matches arbiter INPUT).
- OUTPUT, 32, number of Dual lanes in the response word (matches arbiter OUTPUT).
- SYNC_STAGES, 2, flop stages on every `bus_output` rail before use (minimum 2).
- TIMEOUT, 0, cycles in WAIT before forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  block clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request word offered
- req_ready  out  1  block accepts request this cycle
- req_data  in  INPUT  request word
- rsp_valid  out  1  response word available
- rsp_ready  in  1  consumer takes response this cycle
- rsp_data  out  OUTPUT  decoded response word
- rsp_error  out  1  response invalid (illegal lane or timeout)
- busy  out  1  high in every state except IDLE
- bus_input  out  Dual[INPUT]  to arbiter user input; each Dual is the codebase 2-bit lane {t,f}
- bus_output  in  Dual[OUTPUT]  from arbiter user output; asynchronous to clk

Behaviour:
- Interface (already decided): one clock, clk; reset_n is asynchronous and active-low.
- Encoding is two-phase. Sending bit value v on a lane toggles rail t if v=1, or rail f if v=0; exactly one rail toggles per lane per transfer.
- Reset (reset_n low), applied asynchronously:
  - bus_input all rails 0; snapshot all 0.
  - rsp_valid=0, rsp_data=0, rsp_error=0, req_ready=0, busy=1.
  - Timeout counter 0; state INIT.
  - reset_n must be asserted together with the arbiter's reset.
- Synchronization: `bus_output` passes through SYNC_STAGES flops to give `sync`; `sync_d` is `sync` delayed by one cycle.
- Per-lane decode against snapshot: tog_t = sync.t^snap.t, tog_f = sync.f^snap.f.
  - Lane complete when tog_t^tog_f.
  - Lane illegal when tog_t&tog_f.
- "Stable" means sync==sync_d.
- INIT: stays SYNC_STAGES+1 cycles after reset release, then snapshot<=sync and state goes to IDLE.
- IDLE: req_ready=1.
  - On req_valid&req_ready: for each lane i, toggle bus_input[i].t if req_data[i]=1, else toggle .f. The new bus_input appears the cycle after the handshake (registered); state goes to WAIT.
  - While in IDLE, if stable and any lane toggled (unexpected output): snapshot<=sync silently, no response.
- WAIT: req_ready=0; counter increments each cycle.
  - Completes when every lane is complete-or-illegal AND stable. Then: rsp_data[i]<=tog_t[i]; rsp_error<=OR of illegal lanes; snapshot<=sync; rsp_valid<=1; state goes to HOLD.
  - If TIMEOUT!=0 and counter reaches TIMEOUT first: rsp_data<=0; rsp_error<=1; rsp_valid<=1; snapshot<=sync; state goes to HOLD.
  - Partial toggles never complete early; stability is required in the same cycle as full completion.
- HOLD: rsp_valid=1; rsp_data and rsp_error held stable.
  - On rsp_ready: rsp_valid<=0, counter<=0, state goes to IDLE.
  - req_ready stays 0 in HOLD, including the cycle rsp_ready is high. Next acceptance is one cycle later at the earliest.
- Minimum round-trip latency: handshake → bus_input (+1) → arbiter/core delay → SYNC_STAGES → +1 for the stability check → rsp_valid.
- Reset mid-transfer: everything is reinitialised and any in-flight response is discarded. bus_input returning to 0 is a legal consequence because the arbiter is reset simultaneously.
- bus_input rails change only from flops; there is no combinational path from req_data to bus_input.

Test Plan:
- Reset, then req_data=0x0000_0005. Model returns output lanes toggled as 0x0000_0003 after 7 cycles → bus_input toggles t on bits 0 and 2 and f elsewhere, one cycle after handshake. rsp_valid rises with rsp_data=0x0000_0003, rsp_error=0.
- Back-to-back requests 0xFFFF_FFFF then 0x0, with rsp_ready tied high → second req_ready appears one cycle after the first response handshake. The second transfer toggles all f rails; both responses are correct.
- Model toggles output lanes one at a time over 10 cycles with skew → no rsp_valid until the last lane toggles and sync stays stable one cycle; the decoded word is correct.
- Model toggles both rails of lane 4 → rsp_valid=1, rsp_error=1. The snapshot updates and the next transfer decodes correctly.
- TIMEOUT=16, model never responds → rsp_valid at WAIT cycle 16 with rsp_error=1 and rsp_data=0. With rsp_ready held low, rsp_valid and rsp_data stay held for 20 cycles.
- reset_n pulsed low mid-WAIT → all outputs go to reset values immediately. After INIT (SYNC_STAGES+1 cycles), req_ready=1 and a fresh transfer completes normally.

Source files
------------

// File: rtl/dual_rail_requester.sv
// Clocked client bridge to one user port of the dual-rail arbiter: turns a valid/ready
// request into a two-phase dual-rail transition and decodes the two-phase completion.
module dual_rail_requester #(
    parameter int INPUT       = 32,
    parameter int OUTPUT      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [INPUT-1:0]        req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUTPUT-1:0]       rsp_data,
    output logic                    rsp_error,
    output logic                    busy,
    output logic [INPUT-1:0][1:0]   bus_input,
    input  logic [OUTPUT-1:0][1:0]  bus_output
);

    localparam int CNT_MAX = (TIMEOUT > SYNC_STAGES + 1) ? TIMEOUT : SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, HOLD} state_t;

    state_t                             state;
    logic [CNT_W-1:0]                   count;
    logic [SYNC_STAGES-1:0][OUTPUT-1:0][1:0] sync_pipe;
    logic [OUTPUT-1:0][1:0]             sync;
    logic [OUTPUT-1:0][1:0]             sync_d;
    logic [OUTPUT-1:0][1:0]             snap;
    logic [OUTPUT-1:0]                  tog_t;
    logic [OUTPUT-1:0]                  tog_f;
    logic [INPUT-1:0][1:0]              bus_toggled;
    logic                               all_done;
    logic                               any_illegal;
    logic                               any_tog;
    logic                               stable;

    // bus_output is asynchronous to clk: every rail goes through the flop chain first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_pipe <= '0;
            sync_d    <= '0;
        end else begin
            sync_pipe[0] <= bus_output;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_pipe[s] <= sync_pipe[s-1];
            end
            sync_d <= sync;
        end
    end

    assign sync = sync_pipe[SYNC_STAGES-1];

    for (genvar gi = 0; gi < OUTPUT; gi++) begin : g_decode
        assign tog_t[gi] = sync[gi][1] ^ snap[gi][1];
        assign tog_f[gi] = sync[gi][0] ^ snap[gi][0];
    end

    for (genvar gi = 0; gi < INPUT; gi++) begin : g_encode
        assign bus_toggled[gi] = bus_input[gi] ^ {req_data[gi], ~req_data[gi]};
    end

    // a lane with both rails toggled still counts as finished, but flags an error
    assign all_done    = &(tog_t | tog_f);
    assign any_illegal = |(tog_t & tog_f);
    assign any_tog     = |(tog_t | tog_f);
    assign stable      = (sync == sync_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            count     <= '0;
            snap      <= '0;
            bus_input <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    // let the synchronizer flush before taking the reference snapshot
                    if (count == CNT_W'(SYNC_STAGES)) begin
                        count     <= '0;
                        snap      <= sync;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        bus_input <= bus_toggled;
                        count     <= '0;
                        state     <= WAIT;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else if (stable && any_tog) begin
                        snap <= sync;
                    end
                end
                WAIT: begin
                    count <= count + 1'b1;
                    if (all_done && stable) begin
                        rsp_data  <= tog_t;
                        rsp_error <= any_illegal;
                        rsp_valid <= 1'b1;
                        snap      <= sync;
                        state     <= HOLD;
                    end else if (TIMEOUT != 0 && (count + 1'b1) == CNT_W'(TIMEOUT)) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                        snap      <= sync;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
